// File: rtl/alu_result_reg.sv
// alu_result_reg: output register stage for a pair of alu4 slices forming an
// 8-bit ALU. Captures the byte result and the N/V/Z/C status flags on LOAD.
// An optional decimal-adjust step can be enabled with the macro
// ALU_DECIMAL_ADJUST_EN. When the macro is defined, a decimal LOAD takes two
// cycles. The first cycle latches the raw sum and the second applies the BCD
// correction.
//
// Ports:
//   CLK                in   rising-edge clock
//   RST                in   asynchronous active-high reset
//   F_LO, F_HI         in   result nibbles from the low / high slice
//   CO_LO, CO_HI       in   carry out of the low / high slice
//   A7, B7             in   operand sign bits (B7 before inversion)
//   SUB                in   current operation is a subtract
//   DEC                in   decimal mode requested
//   LOAD               in   single-cycle capture strobe
//   ADD                out  registered 8-bit result
//   FLAG_N/V/Z/C       out  registered status flags
//   VALID              out  one-cycle pulse when ADD/flags are updated
//   BUSY               out  high while the decimal adjust is pending
module alu_result_reg #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] F_LO,
    input  logic [3:0] F_HI,
    input  logic       CO_LO,
    input  logic       CO_HI,
    input  logic       A7,
    input  logic       B7,
    input  logic       SUB,
    input  logic       DEC,
    input  logic       LOAD,
    output logic [7:0] ADD,
    output logic       FLAG_N,
    output logic       FLAG_V,
    output logic       FLAG_Z,
    output logic       FLAG_C,
    output logic       VALID,
    output logic       BUSY
);

    // flags are held as {N,V,Z,C}
    logic [7:0] add_r, add_nxt_s;
    logic [3:0] flags_r, flags_nxt_s;
    logic       valid_r, valid_nxt_s;
    logic [7:0] bin_add_s;
    logic       bin_v_s;

    assign bin_add_s = {F_HI, F_LO};
    // Signed overflow: the operands as seen by the adder have equal signs and
    // the result sign differs from them.
    assign bin_v_s   = (A7 == (B7 ^ SUB)) & (F_HI[3] != A7);

`ifdef ALU_DECIMAL_ADJUST_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ADJUST = 1'b1
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [7:0] raw_r, raw_nxt_s;
    logic       co_lo_r, co_lo_nxt_s;
    logic       co_hi_r, co_hi_nxt_s;
    logic       sub_r, sub_nxt_s;
    logic       v_r, v_nxt_s;
    logic [8:0] adj_s;

    // BCD correction after an add. Returns {C, hi, lo}.
    function automatic logic [8:0] bcd_add_adj(input logic [7:0] raw,
                                               input logic co_lo,
                                               input logic co_hi);
        logic [4:0] lo_v;
        logic [4:0] hi_v;
        logic       c_v;
        lo_v = {1'b0, raw[3:0]};
        if (co_lo || (lo_v > 5'd9)) begin
            lo_v = lo_v + 5'd6;
        end else begin
            lo_v = lo_v;
        end
        // The carry produced by the low correction ripples into the high nibble.
        hi_v = {1'b0, raw[7:4]} + {4'b0000, lo_v[4]};
        if (co_hi || (hi_v > 5'd9)) begin
            hi_v = hi_v + 5'd6;
            c_v  = 1'b1;
        end else begin
            c_v  = co_hi;
        end
        return {c_v, hi_v[3:0], lo_v[3:0]};
    endfunction

    // BCD correction after a subtract. A missing carry means a borrow.
    // Returns {C, hi, lo}.
    function automatic logic [8:0] bcd_sub_adj(input logic [7:0] raw,
                                               input logic co_lo,
                                               input logic co_hi);
        logic [3:0] lo_v;
        logic [3:0] hi_v;
        if (co_lo) begin
            lo_v = raw[3:0];
        end else begin
            lo_v = raw[3:0] - 4'd6;
        end
        if (co_hi) begin
            hi_v = raw[7:4];
        end else begin
            hi_v = raw[7:4] - 4'd6;
        end
        return {co_hi, hi_v, lo_v};
    endfunction

    assign adj_s = sub_r ? bcd_sub_adj(raw_r, co_lo_r, co_hi_r)
                         : bcd_add_adj(raw_r, co_lo_r, co_hi_r);

    // Next-state and next-output decode for the capture / adjust FSM
    always_comb begin
        state_nxt_s = state_r;
        add_nxt_s   = add_r;
        flags_nxt_s = flags_r;
        valid_nxt_s = 1'b0;
        raw_nxt_s   = raw_r;
        co_lo_nxt_s = co_lo_r;
        co_hi_nxt_s = co_hi_r;
        sub_nxt_s   = sub_r;
        v_nxt_s     = v_r;
        case (state_r)
            ST_IDLE: begin
                if (LOAD && DEC) begin
                    raw_nxt_s   = bin_add_s;
                    co_lo_nxt_s = CO_LO;
                    co_hi_nxt_s = CO_HI;
                    sub_nxt_s   = SUB;
                    v_nxt_s     = bin_v_s;
                    state_nxt_s = ST_ADJUST;
                end else if (LOAD) begin
                    add_nxt_s   = bin_add_s;
                    flags_nxt_s = {bin_add_s[7], bin_v_s,
                                   (bin_add_s == 8'h00), CO_HI};
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_ADJUST: begin
                // A LOAD arriving here is dropped.
                add_nxt_s   = adj_s[7:0];
                flags_nxt_s = {adj_s[7], v_r, (adj_s[7:0] == 8'h00), adj_s[8]};
                valid_nxt_s = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and decimal working registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            raw_r   <= 8'h00;
            co_lo_r <= 1'b0;
            co_hi_r <= 1'b0;
            sub_r   <= 1'b0;
            v_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            raw_r   <= raw_nxt_s;
            co_lo_r <= co_lo_nxt_s;
            co_hi_r <= co_hi_nxt_s;
            sub_r   <= sub_nxt_s;
            v_r     <= v_nxt_s;
        end
    end

    assign BUSY = (state_r == ST_ADJUST);
`else
    // The low-slice carry and the decimal request only matter for decimal adjust.
    logic unused_inputs_s;
    assign unused_inputs_s = CO_LO ^ DEC;

    // Next-output decode for the binary-only capture path
    always_comb begin
        add_nxt_s   = add_r;
        flags_nxt_s = flags_r;
        valid_nxt_s = 1'b0;
        if (LOAD) begin
            add_nxt_s   = bin_add_s;
            flags_nxt_s = {bin_add_s[7], bin_v_s, (bin_add_s == 8'h00), CO_HI};
            valid_nxt_s = 1'b1;
        end else begin
            valid_nxt_s = 1'b0;
        end
    end

    assign BUSY = 1'b0;
`endif

    // Result, flag and valid output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            add_r   <= 8'h00;
            flags_r <= FLAGS_RST;
            valid_r <= 1'b0;
        end else begin
            add_r   <= add_nxt_s;
            flags_r <= flags_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign ADD    = add_r;
    assign FLAG_N = flags_r[3];
    assign FLAG_V = flags_r[2];
    assign FLAG_Z = flags_r[1];
    assign FLAG_C = flags_r[0];
    assign VALID  = valid_r;

endmodule

// File: tb/tb_alu_result_reg.sv
// Self-checking bench for alu_result_reg. It uses a scoreboard. Each accepted
// LOAD pushes its expected {ADD, N, V, Z, C}, and every VALID pulse pops one
// entry and compares against it. Scenario tasks add inline latency,
// BUSY and hold checks.
module tb_alu_result_reg;

    localparam logic [3:0] TB_FLAGS_RST = 4'b1010;
`ifdef ALU_DECIMAL_ADJUST_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] add;
        logic [3:0] flags;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] f_lo, f_hi;
    logic       co_lo, co_hi, a7, b7, sub, dec, load;
    logic [7:0] dut_add;
    logic       flag_n, flag_v, flag_z, flag_c, dut_valid, dut_busy;

    int   n_compared = 0;
    int   n_mismatch = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    alu_result_reg #(.FLAGS_RST(TB_FLAGS_RST)) dut (
        .CLK(clk), .RST(rst), .F_LO(f_lo), .F_HI(f_hi), .CO_LO(co_lo),
        .CO_HI(co_hi), .A7(a7), .B7(b7), .SUB(sub), .DEC(dec), .LOAD(load),
        .ADD(dut_add), .FLAG_N(flag_n), .FLAG_V(flag_v), .FLAG_Z(flag_z),
        .FLAG_C(flag_c), .VALID(dut_valid), .BUSY(dut_busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_bin(input logic [7:0] f, input logic chi,
                                       input logic sa, input logic sb,
                                       input logic s);
        exp_t e;
        e.add   = f;
        e.flags = {f[7], ((sa == (sb ^ s)) && (f[7] != sa)), (f == 8'h00), chi};
        return e;
    endfunction

    function automatic exp_t model_dec(input logic [7:0] f, input logic clo,
                                       input logic chi, input logic sa,
                                       input logic sb, input logic s);
        exp_t e;
        int lo, hi, c;
        lo = int'(f[3:0]);
        hi = int'(f[7:4]);
        if (s) begin
            if (!clo) lo = (lo + 10) % 16;
            if (!chi) hi = (hi + 10) % 16;
            c = int'(chi);
        end else begin
            if (clo || lo > 9) lo = lo + 6;
            hi = hi + lo / 16;
            lo = lo % 16;
            if (chi || hi > 9) begin
                hi = (hi + 6) % 16;
                c  = 1;
            end else begin
                c  = int'(chi);
            end
        end
        e.add   = 8'(hi * 16 + lo);
        e.flags = {e.add[7], ((sa == (sb ^ s)) && (f[7] != sa)),
                   (e.add == 8'h00), c[0]};
        return e;
    endfunction

    // Drive one ALU operation A op B and assert LOAD; optionally record the expectation.
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic d, input bit push);
        logic [7:0] bb;
        logic [4:0] lo_sum, hi_sum;
        bb     = s ? ~b : b;
        lo_sum = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'b0000, s};
        hi_sum = {1'b0, a[7:4]} + {1'b0, bb[7:4]} + {4'b0000, lo_sum[4]};
        f_lo  = lo_sum[3:0];
        f_hi  = hi_sum[3:0];
        co_lo = lo_sum[4];
        co_hi = hi_sum[4];
        a7    = a[7];
        b7    = b[7];
        sub   = s;
        dec   = d;
        load  = 1'b1;
        if (push) begin
            if (d && DEC_EN) sb_q.push_back(model_dec({f_hi, f_lo}, co_lo, co_hi, a7, b7, s));
            else             sb_q.push_back(model_bin({f_hi, f_lo}, co_hi, a7, b7, s));
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard: every VALID pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (dut_valid === 1'b1) begin
            n_compared++;
            if (sb_q.size() == 0) begin
                n_mismatch++;
                $display("FAIL sb_unexpected_valid: got ADD=%h NVZC=%b, expected no VALID",
                         dut_add, {flag_n, flag_v, flag_z, flag_c});
            end else begin
                mon_e = sb_q.pop_front();
                if ({dut_add, flag_n, flag_v, flag_z, flag_c} !== mon_e) begin
                    n_mismatch++;
                    $display("FAIL sb_result: got ADD=%h NVZC=%b, expected ADD=%h NVZC=%b",
                             dut_add, {flag_n, flag_v, flag_z, flag_c},
                             mon_e.add, mon_e.flags);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; dec = 1'b0; sub = 1'b0; f_lo = 4'h0; f_hi = 4'h0;
        co_lo = 1'b0; co_hi = 1'b0; a7 = 1'b0; b7 = 1'b0;
        step(); step();
        n_compared++;
        if ({dut_add, flag_n, flag_v, flag_z, flag_c, dut_valid, dut_busy} !==
            {8'h00, TB_FLAGS_RST, 1'b0, 1'b0}) begin
            n_mismatch++;
            $display("FAIL reset_state: got ADD=%h NVZC=%b V=%b B=%b, expected ADD=00 NVZC=%b V=0 B=0",
                     dut_add, {flag_n, flag_v, flag_z, flag_c}, dut_valid, dut_busy, TB_FLAGS_RST);
        end
        // The first LOAD must be taken on the first edge after release.
        rst = 1'b0;
        drive_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        step();
        load = 1'b0;
        n_compared++;
        if (dut_valid !== 1'b1 || dut_add !== 8'h46) begin
            n_mismatch++;
            $display("FAIL first_load_after_reset: got VALID=%b ADD=%h, expected VALID=1 ADD=46",
                     dut_valid, dut_add);
        end
        step();
        // Asynchronous assertion mid-cycle.
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if ({dut_add, flag_n, flag_v, flag_z, flag_c, dut_busy} !== {8'h00, TB_FLAGS_RST, 1'b0}) begin
            n_mismatch++;
            $display("FAIL async_reset: got ADD=%h NVZC=%b B=%b, expected ADD=00 NVZC=%b B=0",
                     dut_add, {flag_n, flag_v, flag_z, flag_c}, dut_busy, TB_FLAGS_RST);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_binary();
        logic [7:0] a, b, last;
        drive_op(8'h50, 8'h50, 1'b0, 1'b0, 1'b1);
        step();
        drive_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
        n_compared++;
        if ({dut_add, flag_n, flag_v, flag_z, flag_c, dut_valid} !== {8'hA0, 4'b1100, 1'b1}) begin
            n_mismatch++;
            $display("FAIL bin_50_plus_50: got ADD=%h NVZC=%b V=%b, expected ADD=A0 NVZC=1100 V=1",
                     dut_add, {flag_n, flag_v, flag_z, flag_c}, dut_valid);
        end
        step();
        load = 1'b0;
        n_compared++;
        if ({dut_add, flag_n, flag_z, flag_c} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
            n_mismatch++;
            $display("FAIL bin_zero: got ADD=%h N=%b Z=%b C=%b, expected ADD=00 N=0 Z=1 C=1",
                     dut_add, flag_n, flag_z, flag_c);
        end
        step();
        // Back-to-back random binary loads, one per cycle.
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            drive_op(a, b, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            step();
        end
        load = 1'b0;
        step();
        last = dut_add;
        step();
        n_compared++;
        if (dut_valid !== 1'b0 || dut_add !== last) begin
            n_mismatch++;
            $display("FAIL idle_hold: got VALID=%b ADD=%h, expected VALID=0 ADD=%h",
                     dut_valid, dut_add, last);
        end
    endtask

`ifdef ALU_DECIMAL_ADJUST_EN
    task automatic test_decimal();
        logic [7:0] prev;
        prev = dut_add;
        drive_op(8'h58, 8'h46, 1'b0, 1'b1, 1'b1);
        step();
        load = 1'b0;
        n_compared++;
        if (dut_busy !== 1'b1 || dut_valid !== 1'b0 || dut_add !== prev) begin
            n_mismatch++;
            $display("FAIL dec_add_edge1: got BUSY=%b VALID=%b ADD=%h, expected BUSY=1 VALID=0 ADD=%h",
                     dut_busy, dut_valid, dut_add, prev);
        end
        step();
        n_compared++;
        if ({dut_add, flag_c, flag_z, dut_valid, dut_busy} !== {8'h04, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_mismatch++;
            $display("FAIL dec_add_edge2: got ADD=%h C=%b Z=%b VALID=%b BUSY=%b, expected ADD=04 C=1 Z=0 VALID=1 BUSY=0",
                     dut_add, flag_c, flag_z, dut_valid, dut_busy);
        end
        // Subtract with a second LOAD during ADJUST that must be dropped.
        drive_op(8'h10, 8'h01, 1'b1, 1'b1, 1'b1);
        step();
        drive_op(8'h33, 8'h22, 1'b0, 1'b0, 1'b0);
        step();
        load = 1'b0;
        n_compared++;
        if (dut_add !== 8'h09 || flag_c !== 1'b1 || dut_valid !== 1'b1) begin
            n_mismatch++;
            $display("FAIL dec_sub_edge2: got ADD=%h C=%b VALID=%b, expected ADD=09 C=1 VALID=1",
                     dut_add, flag_c, dut_valid);
        end
        // A LOAD right after VALID is accepted.
        drive_op(8'h21, 8'h11, 1'b0, 1'b0, 1'b1);
        step();
        load = 1'b0;
        n_compared++;
        if (dut_valid !== 1'b1 || dut_add !== 8'h32) begin
            n_mismatch++;
            $display("FAIL load_after_valid: got VALID=%b ADD=%h, expected VALID=1 ADD=32",
                     dut_valid, dut_add);
        end
        step();
        // Random decimal operations, each followed by its adjust cycle.
        for (int i = 0; i < 12; i++) begin
            drive_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'b1, 1'b1);
            step();
            load = 1'b0;
            step();
        end
        step();
    endtask

    task automatic test_reset_during_adjust();
        drive_op(8'h58, 8'h46, 1'b0, 1'b1, 1'b0);
        step();
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if (dut_busy !== 1'b0 || dut_valid !== 1'b0 || dut_add !== 8'h00) begin
            n_mismatch++;
            $display("FAIL reset_in_adjust: got BUSY=%b VALID=%b ADD=%h, expected BUSY=0 VALID=0 ADD=00",
                     dut_busy, dut_valid, dut_add);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_compared++;
            if (dut_valid !== 1'b0 || dut_busy !== 1'b0) begin
                n_mismatch++;
                $display("FAIL no_valid_after_abort: got VALID=%b BUSY=%b, expected 0 0",
                         dut_valid, dut_busy);
            end
        end
    endtask
`else
    task automatic test_no_decimal();
        drive_op(8'h58, 8'h46, 1'b0, 1'b1, 1'b1);
        step();
        load = 1'b0;
        n_compared++;
        if (dut_add !== 8'h9E || dut_valid !== 1'b1 || dut_busy !== 1'b0) begin
            n_mismatch++;
            $display("FAIL dec_ignored: got ADD=%h VALID=%b BUSY=%b, expected ADD=9E VALID=1 BUSY=0",
                     dut_add, dut_valid, dut_busy);
        end
        // Decimal requests back-to-back still take the single-cycle path.
        for (int i = 0; i < 8; i++) begin
            drive_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'b1, 1'b1);
            step();
            n_compared++;
            if (dut_busy !== 1'b0) begin
                n_mismatch++;
                $display("FAIL busy_tied_low: got BUSY=%b, expected 0", dut_busy);
            end
        end
        load = 1'b0;
        step();
    endtask
`endif

    task automatic test_drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatch++;
            $display("FAIL sb_drain: got %0d pending results, expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_binary();
`ifdef ALU_DECIMAL_ADJUST_EN
        test_decimal();
        test_reset_during_adjust();
`else
        test_no_decimal();
`endif
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_result_reg.md
ALU_RESULT_REG -- requirements
Module: alu_result_reg

Interface
REQ-001 Parameter: FLAGS_RST, default 4'b0000; reset value of {N,V,Z,C}.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 F_LO  in  4  result nibble from the low alu4 slice.
REQ-005 F_HI  in  4  result nibble from the high alu4 slice.
REQ-006 CO_LO  in  1  carry out of the low slice, which is the high-slice carry in.
REQ-007 CO_HI  in  1  carry out of the high slice.
REQ-008 A7  in  1  operand A bit 7.
REQ-009 B7  in  1  operand B bit 7, as presented to the ALU before inversion.
REQ-010 SUB  in  1  1 = current operation is a subtract (A + ~B + CI).
REQ-011 DEC  in  1  1 = decimal mode requested.
REQ-012 LOAD  in  1  capture request; single-cycle strobe.
REQ-013 ADD  out  8  registered result.
REQ-014 FLAG_N, FLAG_V, FLAG_Z, FLAG_C  out  1 each  registered status flags.
REQ-015 VALID  out  1  one-cycle pulse marking new ADD/flags.
REQ-016 BUSY  out  1  high while in ADJUST; LOAD is ignored while BUSY is high.

Function
REQ-017 FSM states and transitions:
- IDLE (BUSY=0).
- ADJUST (BUSY=1).
- IDLE -> ADJUST on LOAD=1 with the decimal path taken (REQ-020).
- ADJUST -> IDLE unconditionally after one cycle.
REQ-018 Binary capture: LOAD=1 in IDLE with DEC=0, or with the decimal path disabled, produces the following at the next edge, with latency 1:
- ADD={F_HI,F_LO}.
- C=CO_HI.
- N=ADD[7].
- Z=(ADD==0).
- V=(A7==(B7^SUB)) & (F_HI[3]!=A7).
- VALID=1.
REQ-019 In IDLE with LOAD=0: ADD and flags hold, and VALID=0.
REQ-020 Decimal capture, edge 1: LOAD=1 in IDLE with DEC=1 latches the raw {F_HI,F_LO}, CO_LO, CO_HI, SUB and binary V internally, sets state to ADJUST, and keeps VALID=0.
- ADD and flags do not change on edge 1.
REQ-021 Decimal add (SUB=0), edge 2:
- Low nibble: if CO_LO=1 or lo>9, add 6; lo = (lo+6) mod 16 and the carry goes to the high nibble.
- High nibble: hi' = hi + lo carry; if CO_HI=1 or hi'>9, add 6 mod 16 and C=1; otherwise C=CO_HI.
REQ-022 Decimal subtract (SUB=1), edge 2:
- If CO_LO=0, lo -= 6 mod 16.
- If CO_HI=0, hi -= 6 mod 16.
- C=CO_HI.
REQ-023 Decimal completion, edge 2:
- N and Z are computed from the adjusted ADD.
- V is the latched binary V.
- VALID=1.
- State returns to IDLE.
REQ-024 LOAD during ADJUST is dropped with no queuing; LOAD in the cycle after VALID is accepted normally.
REQ-025 VALID is never high in two consecutive cycles for the decimal path, and is high for exactly one cycle per accepted LOAD.
REQ-026 Only the low 4 bits of each nibble are kept; there is no 9-bit result, and the carry appears only in FLAG_C.

Reset
REQ-027 While RST=1, regardless of CLK:
- ADD=8'h00.
- {N,V,Z,C}=FLAGS_RST.
- VALID=0, BUSY=0, state=IDLE.
REQ-028 Reset asserted during ADJUST aborts the pending adjust, and no VALID follows the deassertion of RST.
REQ-029 The first LOAD is accepted on the first rising edge after RST deasserts.

Configuration
REQ-030 Macro ALU_DECIMAL_ADJUST_EN:
- Defined: REQ-020..REQ-023 are active and DEC selects the decimal path.
- Undefined: DEC is ignored, every LOAD takes the binary path with latency 1, BUSY is tied to 0, and the ADJUST state does not exist.

Verification
REQ-031 Reset: assert RST mid-cycle -> ADD=00, flags=FLAGS_RST and BUSY=0 immediately, without waiting for a clock edge.
REQ-032 Binary add 0x50+0x50: F=A0, CO_LO=0, CO_HI=0, A7=0, B7=0, SUB=0, LOAD -> next edge ADD=A0, N=1, V=1, Z=0, C=0, VALID pulse.
REQ-033 Binary zero result: F=00, CO_HI=1, LOAD -> ADD=00, Z=1, C=1, N=0.
REQ-034 Decimal add 0x58+0x46 (macro defined): F=9E, CO_LO=0, CO_HI=0, DEC=1, LOAD -> the results arrive over two edges:
- Edge 1: BUSY=1, VALID=0.
- Edge 2: ADD=04, C=1, Z=0, VALID=1, BUSY=0.
REQ-035 Decimal subtract 0x10-0x01 (SUB=1, CI=1): F=0F, CO_LO=0, CO_HI=1, DEC=1 -> edge 2: ADD=09, C=1. A second LOAD asserted during ADJUST produces no extra VALID.
REQ-036 Macro undefined: repeat REQ-034 stimulus -> edge 1: ADD=9E, VALID=1, and BUSY stays 0.
